alu_32bit: RTL and testbench

//   32-bit integer ALU for the RISC-V datapath execute stage. Computes one of
//   the ALU operations on operands a and b, selected by the 4-bit sel code.

---
 rtl/alu_32bit_if.sv | 35 +++
 rtl/alu_32bit.sv | 102 ++++++++++
 tb/tb_alu_32bit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_32bit_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_32bit_if
//  Purpose  : Operand/result bundle for the execute-stage ALU.
//             master drives operands and select, and observes the result and flags.
//             slave receives operands and select, and returns the result and flags.
//  Signals  : a, b   operands (WIDTH)
//             sel    operation select (4)
//             r      registered result (WIDTH)
//             z,c,v,s  registered zero / carry / overflow / sign flags
//  Revision : 1.0  initial release
// ============================================================================
interface alu_32bit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic [WIDTH-1:0] r;
    logic             z;
    logic             c;
    logic             v;
    logic             s;

    modport master (
        output a, b, sel,
        input  r, z, c, v, s
    );

    modport slave (
        input  a, b, sel,
        output r, z, c, v, s
    );
endinterface
`default_nettype wire

// File: rtl/alu_32bit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_32bit
//  Purpose  : Integer ALU for the RISC-V execute stage. One operation per
//             cycle, selected by bus.sel. The result and flags are registered,
//             so they appear one clock after the operands.
//  Ports    : clk  system clock, rising edge
//             rst  synchronous active-high reset (r=0, z=1, c=v=s=0)
//             bus  alu_32bit_if.slave: a, b, sel in; r, z, c, v, s out
//  Revision : 1.0  initial release
// ============================================================================
module alu_32bit #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_32bit_if.slave   bus
);

    localparam int       c_SHW      = $clog2(WIDTH);
    localparam logic [3:0] c_SEL_AND  = 4'b0000;
    localparam logic [3:0] c_SEL_OR   = 4'b0001;
    localparam logic [3:0] c_SEL_ADD  = 4'b0010;
    localparam logic [3:0] c_SEL_XOR  = 4'b0011;
    localparam logic [3:0] c_SEL_SLL  = 4'b0100;
    localparam logic [3:0] c_SEL_SRL  = 4'b0101;
    localparam logic [3:0] c_SEL_SUB  = 4'b0110;
    localparam logic [3:0] c_SEL_SRA  = 4'b0111;
    localparam logic [3:0] c_SEL_SLT  = 4'b1000;
    localparam logic [3:0] c_SEL_SLTU = 4'b1001;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum_ext;
    logic [c_SHW-1:0] w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    logic [WIDTH-1:0] r_res;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_s;

    // Single shared adder: subtraction is a + ~b + 1, so the carry-out of
    // the extended sum is 1 exactly when no borrow occurs (a >= b unsigned).
    assign w_sub     = (bus.sel == c_SEL_SUB);
    assign w_b_op    = w_sub ? ~bus.b : bus.b;
    assign w_sum_ext = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
    assign w_shamt   = bus.b[c_SHW-1:0];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.sel)
            c_SEL_AND:  w_res = bus.a & bus.b;
            c_SEL_OR:   w_res = bus.a | bus.b;
            c_SEL_XOR:  w_res = bus.a ^ bus.b;
            c_SEL_ADD,
            c_SEL_SUB: begin
                w_res = w_sum_ext[WIDTH-1:0];
                w_c   = w_sum_ext[WIDTH];
                // Overflow when both adder inputs share a sign that the sum lost;
                // using the inverted b for SUB covers the a[31]!=b[31] case.
                w_v   = (bus.a[WIDTH-1] == w_b_op[WIDTH-1]) &&
                        (w_sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_SEL_SLL:  w_res = bus.a << w_shamt;
            c_SEL_SRL:  w_res = bus.a >> w_shamt;
            c_SEL_SRA:  w_res = $unsigned($signed(bus.a) >>> w_shamt);
            c_SEL_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_SEL_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default:    w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            r_z   <= 1'b1;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_s   <= 1'b0;
        end else begin
            r_res <= w_res;
            r_z   <= (w_res == '0);
            r_c   <= w_c;
            r_v   <= w_v;
            r_s   <= w_res[WIDTH-1];
        end
    end

    assign bus.r = r_res;
    assign bus.z = r_z;
    assign bus.c = r_c;
    assign bus.v = r_v;
    assign bus.s = r_s;

endmodule
`default_nettype wire

// File: tb/tb_alu_32bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_32bit
//  Purpose  : Self-checking bench for alu_32bit: directed corner cases and
//             randomized operations compared against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_32bit;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        s;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    alu_32bit_if #(.WIDTH(32)) u_if ();

    alu_32bit #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definitions, using wide integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        exp_t        e;
        logic [63:0] wide;
        longint      sw;
        logic [4:0]  sh;
        e    = '0;
        sh   = b[4:0];
        case (sel)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0011: e.r = a ^ b;
            4'b0010: begin
                wide = {32'b0, a} + {32'b0, b};
                e.r  = wide[31:0];
                e.c  = wide[32];
                sw   = longint'($signed(a)) + longint'($signed(b));
                e.v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
            end
            4'b0110: begin
                e.r  = a - b;
                e.c  = (a >= b);
                sw   = longint'($signed(a)) - longint'($signed(b));
                e.v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
            end
            4'b0100: e.r = a << sh;
            4'b0101: e.r = a >> sh;
            4'b0111: e.r = $unsigned($signed(a) >>> sh);
            4'b1000: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: e.r = (a < b) ? 32'd1 : 32'd0;
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        e.s = e.r[31];
        return e;
    endfunction

    // One cycle: drive at negedge, check just after the following posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                        input logic irst, input string tag);
        exp_t e;
        @(negedge clk);
        u_if.a   = a;
        u_if.b   = b;
        u_if.sel = sel;
        rst      = irst;
        if (irst) e = '{r: 32'd0, z: 1'b1, c: 1'b0, v: 1'b0, s: 1'b0};
        else      e = model(a, b, sel);
        @(posedge clk);
        #1;
        chk({tag, ".r"}, u_if.r, e.r);
        chk({tag, ".z"}, {31'b0, u_if.z}, {31'b0, e.z});
        chk({tag, ".c"}, {31'b0, u_if.c}, {31'b0, e.c});
        chk({tag, ".v"}, {31'b0, u_if.v}, {31'b0, e.v});
        chk({tag, ".s"}, {31'b0, u_if.s}, {31'b0, e.s});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [8];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                    32'h80000000, 32'h80000001, 32'h0000001F, 32'h00000020};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        u_if.a   = '0;
        u_if.b   = '0;
        u_if.sel = '0;

        // Reset state, with a live-looking op on the inputs.
        step(32'd2, 32'd2, 4'b0010, 1'b1, "rst0");
        step(32'hFFFFFFFF, 32'd1, 4'b0010, 1'b1, "rst1");

        // Directed cases.
        step(32'd2, 32'd2, 4'b0010, 1'b0, "add2p2");
        step(32'hA, 32'h5, 4'b0000, 1'b0, "and");
        step(32'd10, 32'd5, 4'b0001, 1'b0, "or");
        step(32'd100, 32'd55, 4'b0110, 1'b0, "sub");
        step(32'd100, 32'd55, 4'b0001, 1'b0, "or2");
        step(32'h80000000, 32'd4, 4'b0111, 1'b0, "sra");
        step(32'h80000000, 32'd4, 4'b0101, 1'b0, "srl");
        step(32'h80000000, 32'd1, 4'b1000, 1'b0, "slt");
        step(32'h80000000, 32'd1, 4'b1001, 1'b0, "sltu");
        step(32'h7FFFFFFF, 32'd1, 4'b0010, 1'b0, "addovf");
        step(32'hFFFFFFFF, 32'd1, 4'b0010, 1'b0, "addwrap");
        step(32'd0, 32'd1, 4'b0110, 1'b0, "subbrw");
        step(32'h80000000, 32'd1, 4'b0110, 1'b0, "subovf");
        step(32'h12345678, 32'hFFFFFFE0, 4'b0100, 1'b0, "sll0");
        step(32'h12345678, 32'h00000024, 4'b0100, 1'b0, "sllhi");
        step(32'h12345678, 32'h9ABCDEF0, 4'b0011, 1'b0, "xor");
        step(32'h12345678, 32'h9ABCDEF0, 4'b1111, 1'b0, "ill");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010, 1'b0, "ill2");

        // Mid-stream reset: the op presented during reset is lost.
        step(32'd7, 32'd9, 4'b0010, 1'b0, "pre");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 1'b1, "midrst");
        step(32'd3, 32'd4, 4'b0010, 1'b0, "post");

        // Randomized back-to-back stream.
        for (int i = 0; i < 400; i++) begin
            step(pick(), pick(), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 49) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
